mult_seq: RTL and testbench

MULT_SEQ -- requirements
Module: mult_seq

---
 rtl/mult_seq.sv | 134 +++++++++++++
 tb/tb_mult_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// Sequential radix-2^RADIX_BITS multiplier with signed/unsigned modes.
// Consumes RADIX_BITS multiplier bits per cycle; fixed latency of N+1 cycles.
module mult_seq #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned RADIX_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  input  logic                 start,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned RB_SAFE = (RADIX_BITS == 0) ? 1 : RADIX_BITS;
  localparam int unsigned N      = WIDTH / RB_SAFE;
  localparam int unsigned CW     = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Reject illegal parameterisations at elaboration.
  if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("mult_seq: WIDTH must be in 4..64");
  end
  if (RADIX_BITS == 0 || (WIDTH % RB_SAFE) != 0) begin : g_bad_radix
    $error("mult_seq: RADIX_BITS must divide WIDTH");
  end

  logic [1:0]        state_q,  state_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  logic [PW-1:0]     mcand_q,  mcand_d;   // multiplicand magnitude, pre-shifted to digit position
  logic [WIDTH-1:0]  mplier_q, mplier_d;  // remaining multiplier magnitude digits, LSB first
  logic              neg_q,    neg_d;     // final product must be negated
  logic [PW-1:0]     acc_q,    acc_d;
  logic [PW-1:0]     result_q, result_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;

  logic [WIDTH-1:0]      a_mag;
  logic [WIDTH-1:0]      b_mag;
  logic [RADIX_BITS-1:0] digit;
  logic [PW-1:0]         pp;
  logic [PW-1:0]         sum;
  logic                  accept;

  // Operand magnitudes and the current partial-product sum.
  always_comb begin
    a_mag = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    digit = mplier_q[RADIX_BITS-1:0];
    pp    = mcand_q * PW'(digit);
    sum   = acc_q + pp;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    accept   = start && (state_q != ST_RUN);

    case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << RADIX_BITS;
        mplier_d = mplier_q >> RADIX_BITS;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d  = ST_FIN;
          result_d = neg_q ? (~sum + PW'(1)) : sum;
          done_d   = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Acceptance from IDLE or FIN (back-to-back) captures fresh operands.
    if (accept) begin
      state_d  = ST_RUN;
      cnt_d    = '0;
      mcand_d  = PW'(a_mag);
      mplier_d = b_mag;
      neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_d    = '0;
      busy_d   = 1'b1;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed corner cases on the default
// configuration plus randomized WIDTH=8 radix sweep against an arithmetic model.
module tb_mult_seq;

  logic        clk;
  logic        reset;
  logic [15:0] a, b;
  logic        signed_mode, start;
  logic        busy, done;
  logic [31:0] result;
  logic        sw_reset;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_res;

  mult_seq #(.WIDTH(16), .RADIX_BITS(2)) u_dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .signed_mode(signed_mode),
    .start(start), .busy(busy), .result(result), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference product: plain integer arithmetic on interpreted operand values.
  function automatic logic [63:0] ref_mul(input int unsigned w, input logic [63:0] x,
                                          input logic [63:0] y, input bit sm);
    logic [63:0] mask, mask2;
    longint sx, sy, prod;
    mask  = (64'd1 << w) - 64'd1;
    mask2 = (64'd1 << (2 * w)) - 64'd1;
    x = x & mask;
    y = y & mask;
    sx = longint'(x);
    sy = longint'(y);
    if (sm && x[w-1]) sx = sx - (longint'(1) << w);
    if (sm && y[w-1]) sy = sy - (longint'(1) << w);
    prod = sx * sy;
    return 64'(prod) & mask2;
  endfunction

  // One operation on the default DUT: checks latency, busy span, hold and result.
  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input bit sm, input logic [31:0] exp);
    int lat, nbusy;
    bit held;
    @(negedge clk);
    a = ia; b = ib; signed_mode = sm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
    lat = 1; nbusy = 0; held = 1'b1;
    while (lat < 40) begin
      if (done) break;
      if (busy) nbusy++;
      if (result !== last_res) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd9);
    chk({tag, "_busy"}, 64'(nbusy), 64'd8);
    chk({tag, "_hold"}, 64'(held), 64'd1);
    chk({tag, "_res"}, 64'(result), 64'(exp));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    last_res = exp;
  endtask

  // Parameter sweep: WIDTH=8, RADIX_BITS in {1,2,4,8}.
  initial begin
    sw_reset = 1'b0;
    repeat (3) @(negedge clk);
    sw_reset = 1'b1;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int unsigned R  = 1 << gi;
    localparam int unsigned NS = 8 / R;
    logic [7:0]  sa, sb;
    logic        ssm, sst, sbusy, sdone;
    logic [15:0] sres;
    bit          fin;

    mult_seq #(.WIDTH(8), .RADIX_BITS(R)) u_sw (
      .clk(clk), .reset(sw_reset), .a(sa), .b(sb), .signed_mode(ssm),
      .start(sst), .busy(sbusy), .result(sres), .done(sdone)
    );

    initial begin : sw_run
      logic [7:0]  xa, xb;
      bit          xm;
      logic [15:0] ex;
      int          lat;
      fin = 1'b0; sa = '0; sb = '0; ssm = 1'b0; sst = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 24; i++) begin
        xa = 8'($urandom); xb = 8'($urandom); xm = 1'($urandom);
        if (i == 0) begin xa = 8'h80; xb = 8'h80; xm = 1'b1; end
        if (i == 1) begin xa = 8'hFF; xb = 8'hFF; xm = 1'b0; end
        if (i == 2) xa = 8'h00;
        if (i == 3) begin xa = 8'h80; xb = 8'h01; xm = 1'b1; end
        ex = 16'(ref_mul(8, 64'(xa), 64'(xb), xm));
        sa = xa; sb = xb; ssm = xm; sst = 1'b1;
        @(negedge clk);
        sst = 1'b0; sa = 8'($urandom); sb = 8'($urandom);
        lat = 1;
        while (lat < 30 && !sdone) begin
          @(negedge clk);
          lat++;
        end
        chk($sformatf("r%0d_lat", R), 64'(lat), 64'(NS + 1));
        chk($sformatf("r%0d_res_%0h_%0h_%0d", R, xa, xb, xm), 64'(sres), 64'(ex));
        @(negedge clk);
      end
      fin = 1'b1;
    end
  end

  // Directed tests on the default configuration.
  initial begin : main
    int c, nd, d1, d2;
    logic [31:0] r1, r2;
    logic [15:0] ra, rb;
    bit rm;

    reset = 1'b0; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    last_res = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op("u_max", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    run_op("s_m1m1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
    run_op("s_minmin", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
    run_op("s_min1", 16'h8000, 16'h0001, 1'b1, 32'hFFFF8000);
    run_op("zero", 16'h0000, 16'h1234, 1'b0, 32'h00000000);

    // Start while busy is ignored.
    @(negedge clk);
    a = 16'd3; b = 16'd5; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 16'd7; b = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0; d1 = 0; r1 = '0;
    for (c = 5; c < 35; c++) begin
      if (done) begin nd++; d1 = c; r1 = result; end
      @(negedge clk);
    end
    chk("ign_ndone", 64'(nd), 64'd1);
    chk("ign_lat", 64'(d1), 64'd9);
    chk("ign_res", 64'(r1), 64'd15);
    last_res = 32'd15;

    // Back-to-back with start held high.
    a = 16'd2; b = 16'd3; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    c = 1; nd = 0; d1 = 0; d2 = 0; r1 = '0; r2 = '0;
    while (c < 40) begin
      if (done) begin
        nd++;
        if (nd == 1) begin d1 = c; r1 = result; a = 16'd4; b = 16'd5; end
        else begin d2 = c; r2 = result; start = 1'b0; break; end
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk("b2b_lat1", 64'(d1), 64'd9);
    chk("b2b_gap", 64'(d2 - d1), 64'd9);
    chk("b2b_res1", 64'(r1), 64'd6);
    chk("b2b_res2", 64'(r2), 64'd20);
    @(negedge clk);
    chk("b2b_idle", 64'(busy), 64'd0);
    last_res = 32'd20;

    // Reset in the middle of an operation aborts it.
    a = 16'h1234; b = 16'h5678; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_nodone", 64'(nd), 64'd0);
    last_res = '0;
    run_op("after_rst", 16'h1234, 16'h5678, 1'b0, 32'h06260060);

    // Randomized operands against the reference model.
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom);
      run_op($sformatf("rnd%0d", i), ra, rb, rm, 32'(ref_mul(16, 64'(ra), 64'(rb), rm)));
    end

    c = 0;
    while (c < 5000 && !(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin && g_sw[3].fin)) begin
      @(negedge clk);
      c++;
    end
    chk("sweep_finished",
        64'({g_sw[0].fin, g_sw[1].fin, g_sw[2].fin, g_sw[3].fin}), 64'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
